// File: rtl/life_engine_if.sv
// Control, edit and display bus of the Game-of-Life engine.
// The master drives controls and reads status; the slave is the engine.
interface life_engine_if #(
    parameter int unsigned BIT_WIDTH  = 3,
    parameter int unsigned BIT_HEIGHT = 3
);
    logic                            frame_tick;
    logic                            run;
    logic                            step;
    logic                            wrap;
    logic                            clear;
    logic                            wr_en;
    logic [BIT_WIDTH-1:0]            wr_x;
    logic [BIT_HEIGHT-1:0]           wr_y;
    logic                            wr_val;
    logic [BIT_WIDTH-1:0]            rd_x;
    logic [BIT_HEIGHT-1:0]           rd_y;
    logic                            rd_cell;
    logic                            busy;
    logic [15:0]                     gen_count;
    logic [BIT_WIDTH+BIT_HEIGHT:0]   population;
    logic                            overrun;

    modport master (
        output frame_tick, run, step, wrap, clear, wr_en, wr_x, wr_y, wr_val, rd_x, rd_y,
        input  rd_cell, busy, gen_count, population, overrun
    );

    modport slave (
        input  frame_tick, run, step, wrap, clear, wr_en, wr_x, wr_y, wr_val, rd_x, rd_y,
        output rd_cell, busy, gen_count, population, overrun
    );
endinterface

// File: rtl/life_engine.sv
// Double-buffered Game-of-Life engine: computes one cell per clk into the back
// buffer, then swaps it into the display-facing front buffer in a single clk.
module life_engine #(
    parameter int unsigned BIT_WIDTH      = 3,
    parameter int unsigned BIT_HEIGHT     = 3,
    parameter int unsigned FRAMES_PER_GEN = 60,
    parameter logic [(2**(BIT_WIDTH+BIT_HEIGHT))-1:0] INIT_PATTERN = 64'h0000_0000_0808_0800
) (
    input  logic         clk,
    input  logic         reset,
    life_engine_if.slave bus
);
    localparam int unsigned IW   = BIT_WIDTH + BIT_HEIGHT;
    localparam int unsigned SIZE = 2 ** IW;
    localparam int unsigned PW   = IW + 1;
    localparam int unsigned FW   = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

    localparam logic [FW-1:0]         FCNT_LAST = FW'(FRAMES_PER_GEN - 1);
    localparam logic [IW-1:0]         IDX_LAST  = '1;
    localparam logic [PW-1:0]         INIT_POP  = PW'($countones(INIT_PATTERN));
    localparam logic [BIT_WIDTH-1:0]  X_ONE     = BIT_WIDTH'(1);
    localparam logic [BIT_WIDTH-1:0]  X_MAX     = '1;
    localparam logic [BIT_HEIGHT-1:0] Y_ONE     = BIT_HEIGHT'(1);
    localparam logic [BIT_HEIGHT-1:0] Y_MAX     = '1;

    typedef enum logic [1:0] {IDLE, COMPUTE, SWAP} state_t;

    state_t              state_q, state_d;
    logic [SIZE-1:0]     front, back;
    logic [IW-1:0]       idx;
    logic [PW-1:0]       pop_acc;
    logic [PW-1:0]       population_q;
    logic [15:0]         gen_q;
    logic [FW-1:0]       fcnt;
    logic                overrun_q;
    logic                wrap_q;

    logic                trigger;
    logic                busy;
    logic [IW-1:0]       wr_idx;

    logic [BIT_WIDTH-1:0]  cx;
    logic [BIT_HEIGHT-1:0] cy;
    logic [BIT_WIDTH-1:0]  xs [3];
    logic [BIT_HEIGHT-1:0] ys [3];
    logic [2:0]            xv, yv;
    logic [3:0]            ncount;
    logic                  new_cell;

    assign trigger = (bus.run && bus.frame_tick && (fcnt == FCNT_LAST)) || bus.step;
    assign busy    = (state_q != IDLE);
    assign wr_idx  = {bus.wr_y, bus.wr_x};

    assign bus.rd_cell    = front[{bus.rd_y, bus.rd_x}];
    assign bus.busy       = busy;
    assign bus.gen_count  = gen_q;
    assign bus.population = population_q;
    assign bus.overrun    = overrun_q;

    // Neighbour offsets -1/0/+1 wrap naturally in the coordinate width; the
    // valid flags mask off the wrapped ones when the board is bounded.
    always_comb begin
        cx = idx[BIT_WIDTH-1:0];
        cy = idx[IW-1:BIT_WIDTH];
        xs[0] = cx - X_ONE;
        xs[1] = cx;
        xs[2] = cx + X_ONE;
        ys[0] = cy - Y_ONE;
        ys[1] = cy;
        ys[2] = cy + Y_ONE;
        xv = {wrap_q || (cx != X_MAX), 1'b1, wrap_q || (cx != '0)};
        yv = {wrap_q || (cy != Y_MAX), 1'b1, wrap_q || (cy != '0)};
        ncount = '0;
        for (int unsigned j = 0; j < 3; j++) begin
            for (int unsigned i = 0; i < 3; i++) begin
                if (!(i == 1 && j == 1) && xv[i] && yv[j]) begin
                    ncount = ncount + {3'b000, front[{ys[j], xs[i]}]};
                end
            end
        end
        new_cell = (ncount == 4'd3) || (front[idx] && (ncount == 4'd2));
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (trigger) state_d = COMPUTE;
                COMPUTE: if (idx == IDX_LAST) state_d = SWAP;
                SWAP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            front        <= INIT_PATTERN;
            back         <= '0;
            idx          <= '0;
            pop_acc      <= '0;
            population_q <= INIT_POP;
            gen_q        <= '0;
            fcnt         <= '0;
            overrun_q    <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            state_q <= state_d;

            if (bus.run && bus.frame_tick) begin
                fcnt <= (fcnt == FCNT_LAST) ? '0 : fcnt + FW'(1);
            end

            if (trigger && busy && !bus.clear) begin
                overrun_q <= 1'b1;
            end

            if (bus.clear) begin
                front        <= '0;
                back         <= '0;
                population_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        // The write lands in front before COMPUTE starts, so a
                        // same-clk trigger sees the edited board.
                        if (bus.wr_en) begin
                            front[wr_idx] <= bus.wr_val;
                            if (bus.wr_val && !front[wr_idx]) begin
                                population_q <= population_q + PW'(1);
                            end else if (!bus.wr_val && front[wr_idx]) begin
                                population_q <= population_q - PW'(1);
                            end
                        end
                        if (trigger) begin
                            wrap_q  <= bus.wrap;
                            idx     <= '0;
                            pop_acc <= '0;
                        end
                    end
                    COMPUTE: begin
                        back[idx] <= new_cell;
                        pop_acc   <= pop_acc + PW'(new_cell);
                        if (idx != IDX_LAST) begin
                            idx <= idx + IW'(1);
                        end
                    end
                    SWAP: begin
                        front        <= back;
                        population_q <= pop_acc;
                        gen_q        <= gen_q + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_life_engine.sv
// Self-checking bench for life_engine: directed scenarios, a write table and
// randomized boards compared against an integer-coordinate Life model.
module tb_life_engine;
    localparam int BW  = 3;
    localparam int BH  = 3;
    localparam int W   = 8;
    localparam int H   = 8;
    localparam int FPG = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    life_engine_if #(.BIT_WIDTH(BW), .BIT_HEIGHT(BH)) bus ();

    life_engine #(
        .BIT_WIDTH(BW),
        .BIT_HEIGHT(BH),
        .FRAMES_PER_GEN(FPG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] mb;
    int          mgen;
    logic        movr;

    typedef struct {
        logic [2:0] x;
        logic [2:0] y;
        logic       v;
        int         pop;
    } wr_vec_t;
    wr_vec_t tbl [6];

    function automatic logic [63:0] next_gen(input logic [63:0] b, input logic wr);
        logic [63:0] r;
        r = '0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                int n;
                n = 0;
                for (int dy = -1; dy <= 1; dy++) begin
                    for (int dx = -1; dx <= 1; dx++) begin
                        int nx, ny;
                        nx = x + dx;
                        ny = y + dy;
                        if (wr) begin
                            nx = (nx + W) % W;
                            ny = (ny + H) % H;
                        end
                        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < W && ny >= 0 && ny < H)
                            n += int'(b[ny*W + nx]);
                    end
                end
                r[y*W + x] = (n == 3) || (b[y*W + x] && n == 2);
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        mb   = 64'h0000_0000_0808_0800;
        mgen = 0;
        movr = 1'b0;
    endtask

    task automatic read_board(output logic [63:0] b);
        for (int i = 0; i < 64; i++) begin
            bus.rd_x = BW'(i % W);
            bus.rd_y = BH'(i / W);
            #1;
            b[i] = bus.rd_cell;
        end
        @(negedge clk);
    endtask

    task automatic check_state(input string name);
        logic [63:0] b;
        read_board(b);
        check({name, "_board"}, b, mb);
        check({name, "_pop"}, 64'(bus.population), 64'($countones(mb)));
        check({name, "_gen"}, 64'(bus.gen_count), 64'(mgen));
        check({name, "_ovr"}, 64'(bus.overrun), 64'(movr));
    endtask

    task automatic do_write(input int x, input int y, input logic v);
        bus.wr_en  = 1'b1;
        bus.wr_x   = BW'(x);
        bus.wr_y   = BH'(y);
        bus.wr_val = v;
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_step();
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        mb = '0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (n >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_timeout: got busy after %0d clks expected idle", n);
        end
    endtask

    task automatic load_board(input logic [63:0] b);
        pulse_clear();
        for (int i = 0; i < 64; i++) do_write(i % W, i / W, b[i]);
        mb = b;
    endtask

    task automatic tick_frame();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        cyc(99);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [63:0] b;
        logic [63:0] seen;
        logic        w;

        tbl[0] = '{x: 3'd7, y: 3'd0, v: 1'b1, pop: 1};
        tbl[1] = '{x: 3'd0, y: 3'd0, v: 1'b1, pop: 2};
        tbl[2] = '{x: 3'd1, y: 3'd0, v: 1'b1, pop: 3};
        tbl[3] = '{x: 3'd1, y: 3'd0, v: 1'b1, pop: 3};
        tbl[4] = '{x: 3'd5, y: 3'd5, v: 1'b1, pop: 4};
        tbl[5] = '{x: 3'd5, y: 3'd5, v: 1'b0, pop: 3};

        {bus.frame_tick, bus.run, bus.step, bus.wrap, bus.clear, bus.wr_en, bus.wr_val} = '0;
        bus.wr_x = '0; bus.wr_y = '0; bus.rd_x = '0; bus.rd_y = '0;
        @(negedge clk);

        // 1: reset state, blinker oscillation, 65-clk busy window
        do_reset();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check_state("rst");
        pulse_step();
        wait_idle(n);
        check("t1_busy_len", 64'(n), 64'd65);
        read_board(b);
        check("t1_gen1_board", b, 64'h0000_0000_001C_0000);
        check("t1_gen1_pop", 64'(bus.population), 64'd3);
        check("t1_gen1_cnt", 64'(bus.gen_count), 64'd1);
        pulse_step();
        wait_idle(n);
        mgen = 2;
        check_state("t1_gen2");

        // 2: write table, then toroidal vs bounded blinker across the edge
        pulse_clear();
        for (int i = 0; i < 6; i++) begin
            do_write(int'(tbl[i].x), int'(tbl[i].y), tbl[i].v);
            mb[int'(tbl[i].y)*W + int'(tbl[i].x)] = tbl[i].v;
            bus.rd_x = tbl[i].x;
            bus.rd_y = tbl[i].y;
            #1;
            check($sformatf("t2_wr%0d_cell", i), 64'(bus.rd_cell), 64'(tbl[i].v));
            check($sformatf("t2_wr%0d_pop", i), 64'(bus.population), 64'(tbl[i].pop));
            @(negedge clk);
        end
        bus.wrap = 1'b1;
        pulse_step();
        wait_idle(n);
        mgen++;
        read_board(b);
        check("t2_wrap_board", b, 64'h0100_0000_0000_0101);
        mb = next_gen(mb, 1'b1);
        check_state("t2_wrap");
        load_board(64'h0000_0000_0000_0083);
        bus.wrap = 1'b0;
        pulse_step();
        wait_idle(n);
        mgen++;
        read_board(b);
        check("t2_bounded_board", b, 64'd0);
        check("t2_bounded_pop", 64'(bus.population), 64'd0);

        // 3: free-run every FPG frames, then hold with run low
        do_reset();
        bus.run = 1'b1;
        repeat (6) tick_frame();
        for (int g = 0; g < 3; g++) mb = next_gen(mb, 1'b0);
        mgen = 3;
        check_state("t3_run");
        bus.run = 1'b0;
        repeat (4) tick_frame();
        check_state("t3_hold");

        // 4: overrun on second trigger, writes while busy dropped
        pulse_step();
        cyc(10);
        pulse_step();
        do_write(0, 7, 1'b1);
        wait_idle(n);
        mb = next_gen(mb, 1'b0);
        mgen++;
        movr = 1'b1;
        check_state("t4_overrun");

        // 5: clear aborts a generation; still-life block survives
        pulse_step();
        cyc(20);
        pulse_clear();
        check("t5_busy_after_clear", 64'(bus.busy), 64'd0);
        check_state("t5_cleared");
        do_write(3, 3, 1'b1);
        do_write(4, 3, 1'b1);
        do_write(3, 4, 1'b1);
        do_write(4, 4, 1'b1);
        pulse_step();
        wait_idle(n);
        mb = 64'h0000_0018_1800_0000;
        mgen++;
        check_state("t5_block");

        // 6: display reads old board for the whole COMPUTE/SWAP window
        load_board({$urandom, $urandom});
        bus.wrap = 1'b1;
        pulse_step();
        for (int i = 0; i < 64; i++) begin
            bus.rd_x = BW'(i % W);
            bus.rd_y = BH'(i / W);
            #1;
            seen[i] = bus.rd_cell;
            @(negedge clk);
        end
        check("t6_busy_in_swap", 64'(bus.busy), 64'd1);
        check("t6_old_during_gen", seen, mb);
        wait_idle(n);
        mb = next_gen(mb, 1'b1);
        mgen++;
        check_state("t6_new");

        // randomized boards and edge modes, two generations each
        for (int r = 0; r < 6; r++) begin
            load_board({$urandom, $urandom} & {$urandom, $urandom} | {$urandom, $urandom} & 64'h00FF_0000_0000_FF00);
            for (int g = 0; g < 2; g++) begin
                w = 1'($urandom_range(0, 1));
                bus.wrap = w;
                pulse_step();
                bus.wrap = ~w;
                wait_idle(n);
                mb = next_gen(mb, w);
                mgen++;
                check_state($sformatf("rnd%0d_g%0d", r, g));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
